// File: rtl/dual_port_ram_byte_enable.sv
// True dual-port RAM on one clock with per-lane write enables, read latency
// of 1 or 2 enabled cycles, read-valid tracking and write-through forwarding.
// Port A wins lanes written by both ports at one address. Collision flags
// that overlap one cycle later.
module dual_port_ram_byte_enable #(
  parameter  int Width     = 32,
  parameter  int Depth     = 1024,
  parameter  int ByteWidth = 8,
  parameter  int Latency   = 1,
  localparam int AW        = $clog2(Depth),
  localparam int NB        = Width / ByteWidth
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             ClkEnable_A,
  input  logic [AW-1:0]    Address_A,
  input  logic [Width-1:0] WrData_A,
  input  logic [NB-1:0]    ByteEnable_A,
  input  logic             WrEnable_A,
  input  logic             RdEnable_A,
  output logic [Width-1:0] RdData_A,
  output logic             RdValid_A,
  input  logic             ClkEnable_B,
  input  logic [AW-1:0]    Address_B,
  input  logic [Width-1:0] WrData_B,
  input  logic [NB-1:0]    ByteEnable_B,
  input  logic             WrEnable_B,
  input  logic             RdEnable_B,
  output logic [Width-1:0] RdData_B,
  output logic             RdValid_B,
  output logic             Collision
);

  localparam logic [AW:0] DepthLim = (AW+1)'(Depth);

  logic [Width-1:0] mem [Depth];

  // Index 0 is port A, index 1 is port B.
  logic             ce       [2];
  logic [AW-1:0]    addr     [2];
  logic [Width-1:0] wdata    [2];
  logic [NB-1:0]    be       [2];
  logic             wen      [2];
  logic             ren      [2];
  logic             in_range [2];
  logic             wr_go    [2];
  logic [Width-1:0] rd_word  [2];
  logic [Width-1:0] rd_data  [2];
  logic             rd_vld   [2];
  logic             coll_next;

  assign ce[0]    = ClkEnable_A;
  assign ce[1]    = ClkEnable_B;
  assign addr[0]  = Address_A;
  assign addr[1]  = Address_B;
  assign wdata[0] = WrData_A;
  assign wdata[1] = WrData_B;
  assign be[0]    = ByteEnable_A;
  assign be[1]    = ByteEnable_B;
  assign wen[0]   = WrEnable_A;
  assign wen[1]   = WrEnable_B;
  assign ren[0]   = RdEnable_A;
  assign ren[1]   = RdEnable_B;

  assign RdData_A  = rd_data[0];
  assign RdValid_A = rd_vld[0];
  assign RdData_B  = rd_data[1];
  assign RdValid_B = rd_vld[1];

  // Overlay the enabled lanes of new_word onto old_word.
  function automatic logic [Width-1:0] merge_lanes(input logic [Width-1:0] old_word,
                                                   input logic [Width-1:0] new_word,
                                                   input logic [NB-1:0]    lanes);
    logic [Width-1:0] w;
    w = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) w[i*ByteWidth +: ByteWidth] = new_word[i*ByteWidth +: ByteWidth];
    end
    return w;
  endfunction

  // Qualify each port's write: enabled, strobed and inside the array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, addr[p]} < DepthLim);
      wr_go[p]    = ce[p] & wen[p] & in_range[p];
    end
  end

  // Read word as it will stand after this edge: B's lanes, then A's on top.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) begin
        rd_word[p] = mem[addr[p]];
        if (wr_go[1] && (addr[1] == addr[p])) rd_word[p] = merge_lanes(rd_word[p], wdata[1], be[1]);
        if (wr_go[0] && (addr[0] == addr[p])) rd_word[p] = merge_lanes(rd_word[p], wdata[0], be[0]);
      end
    end
  end

  // Lane writes; A is assigned last so it owns lanes both ports enable.
  always_ff @(posedge ipClk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_go[1] && be[1][i]) mem[addr[1]][i*ByteWidth +: ByteWidth] <= wdata[1][i*ByteWidth +: ByteWidth];
      if (wr_go[0] && be[0][i]) mem[addr[0]][i*ByteWidth +: ByteWidth] <= wdata[0][i*ByteWidth +: ByteWidth];
    end
  end

  assign coll_next = wr_go[0] & wr_go[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));

  // One-cycle pulse when both ports wrote at least one common lane.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) Collision <= 1'b0;
    else         Collision <= coll_next;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [Width-1:0] data_p1;
    logic             vld_p1;

    // Stage 1: capture the forwarded word when a read issues; bubble clears valid.
    always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else if (ce[p]) begin
        vld_p1 <= ren[p];
        if (ren[p]) data_p1 <= rd_word[p];
      end
    end

    if (Latency == 2) begin : g_lat2
      logic [Width-1:0] data_p2;
      logic             vld_p2;

      // Stage 2: optional output register, advancing only on enabled edges.
      always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
        end else if (ce[p]) begin
          vld_p2 <= vld_p1;
          if (vld_p1) data_p2 <= data_p1;
        end
      end

      assign rd_data[p] = data_p2;
      assign rd_vld[p]  = vld_p2;
    end else begin : g_lat1
      assign rd_data[p] = data_p1;
      assign rd_vld[p]  = vld_p1;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_byte_enable.sv
// Bench for dual_port_ram_byte_enable: a Latency=1 and a Latency=2 instance
// share the same stimulus; both are compared with a word-level reference.
module tb_dual_port_ram_byte_enable;
  localparam int W  = 32;
  localparam int D  = 1000;
  localparam int BW = 8;
  localparam int NB = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ce   [2];
  logic [AW-1:0] addr [2];
  logic [W-1:0]  wd   [2];
  logic [NB-1:0] be   [2];
  logic          we   [2];
  logic          re   [2];

  // [d][p]: d=0 is the Latency=1 instance, d=1 the Latency=2 instance.
  logic [W-1:0] out_d [2][2];
  logic         out_v [2][2];
  logic         out_c [2];

  int total = 0;
  int bad   = 0;

  // Reference: memory image plus per-port history of reads indexed by enabled edge.
  logic [W-1:0] mem_m [D];
  logic         hv    [2][4096];
  logic [W-1:0] hd    [2][4096];
  int           cnt   [2];
  int           rbase [2];
  logic [W-1:0] exp_d [2][2];
  logic         exp_v [2][2];
  logic         exp_c;

  dual_port_ram_byte_enable #(.Width(W), .Depth(D), .ByteWidth(BW), .Latency(1)) dut_l1 (
    .ipClk(clk), .ipReset(rst),
    .ClkEnable_A(ce[0]), .Address_A(addr[0]), .WrData_A(wd[0]), .ByteEnable_A(be[0]),
    .WrEnable_A(we[0]), .RdEnable_A(re[0]), .RdData_A(out_d[0][0]), .RdValid_A(out_v[0][0]),
    .ClkEnable_B(ce[1]), .Address_B(addr[1]), .WrData_B(wd[1]), .ByteEnable_B(be[1]),
    .WrEnable_B(we[1]), .RdEnable_B(re[1]), .RdData_B(out_d[0][1]), .RdValid_B(out_v[0][1]),
    .Collision(out_c[0]));

  dual_port_ram_byte_enable #(.Width(W), .Depth(D), .ByteWidth(BW), .Latency(2)) dut_l2 (
    .ipClk(clk), .ipReset(rst),
    .ClkEnable_A(ce[0]), .Address_A(addr[0]), .WrData_A(wd[0]), .ByteEnable_A(be[0]),
    .WrEnable_A(we[0]), .RdEnable_A(re[0]), .RdData_A(out_d[1][0]), .RdValid_A(out_v[1][0]),
    .ClkEnable_B(ce[1]), .Address_B(addr[1]), .WrData_B(wd[1]), .ByteEnable_B(be[1]),
    .WrEnable_B(we[1]), .RdEnable_B(re[1]), .RdData_B(out_d[1][1]), .RdValid_B(out_v[1][1]),
    .Collision(out_c[1]));

  // Apply one rising edge's effect: writes land first, reads see the result.
  function automatic void model_step();
    logic inr [2];
    for (int p = 0; p < 2; p++) inr[p] = (int'(addr[p]) < D);
    exp_c = ce[0] && ce[1] && we[0] && we[1] && inr[0] && inr[1] &&
            (addr[0] == addr[1]) && ((be[0] & be[1]) != '0);
    for (int p = 1; p >= 0; p--) begin
      if (ce[p] && we[p] && inr[p]) begin
        for (int l = 0; l < NB; l++)
          if (be[p][l]) mem_m[addr[p]][l*BW +: BW] = wd[p][l*BW +: BW];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (ce[p]) begin
        cnt[p]++;
        hv[p][cnt[p]] = re[p];
        hd[p][cnt[p]] = inr[p] ? mem_m[addr[p]] : '0;
        for (int d = 0; d < 2; d++) begin
          int idx;
          idx = cnt[p] - d;
          if (idx > rbase[p] && hv[p][idx]) begin
            exp_v[d][p] = 1'b1;
            exp_d[d][p] = hd[p][idx];
          end else begin
            exp_v[d][p] = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      rbase[p] = cnt[p];
      for (int d = 0; d < 2; d++) begin
        exp_v[d][p] = 1'b0;
        exp_d[d][p] = '0;
      end
    end
    exp_c = 1'b0;
  endfunction

  task automatic set_idle();
    for (int p = 0; p < 2; p++) begin
      ce[p] = 1'b1; addr[p] = '0; wd[p] = '0; be[p] = '0; we[p] = 1'b0; re[p] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        total++;
        if (out_v[d][p] !== 1'b0) begin bad++; $display("FAIL reset_valid d%0d p%0d: got %b want 0", d, p, out_v[d][p]); end
        total++;
        if (out_d[d][p] !== '0) begin bad++; $display("FAIL reset_data d%0d p%0d: got %h want 0", d, p, out_d[d][p]); end
      end
      total++;
      if (out_c[d] !== 1'b0) begin bad++; $display("FAIL reset_coll d%0d: got %b want 0", d, out_c[d]); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D / 2; i++) begin
      set_idle();
      we[0] = 1'b1; addr[0] = AW'(2*i);   wd[0] = $urandom; be[0] = 4'hF;
      we[1] = 1'b1; addr[1] = AW'(2*i+1); wd[1] = $urandom; be[1] = 4'hF;
      cycle();
      total++;
      if (out_c[1] !== 1'b0) begin bad++; $display("FAIL fill_coll @%0d: got %b want 0", i, out_c[1]); end
    end
  endtask

  task automatic test_write_read();
    set_idle(); we[0] = 1'b1; addr[0] = 10'd5; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
    cycle();
    set_idle(); re[0] = 1'b1; addr[0] = 10'd5;
    cycle();
    total++;
    if (out_v[0][0] !== 1'b1 || out_d[0][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_l1: got v=%b d=%h want v=1 d=deadbeef", out_v[0][0], out_d[0][0]); end
    total++;
    if (out_v[1][0] !== 1'b0) begin bad++; $display("FAIL wr_rd_l2_early: got v=%b want 0", out_v[1][0]); end
    set_idle();
    cycle();
    total++;
    if (out_v[1][0] !== 1'b1 || out_d[1][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_l2: got v=%b d=%h want v=1 d=deadbeef", out_v[1][0], out_d[1][0]); end
    total++;
    if (out_v[0][0] !== 1'b0) begin bad++; $display("FAIL wr_rd_l1_bubble: got v=%b want 0", out_v[0][0]); end
    cycle();
    total++;
    if (out_v[1][0] !== 1'b0 || out_d[1][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_l2_once: got v=%b d=%h want v=0 d=deadbeef", out_v[1][0], out_d[1][0]); end
  endtask

  task automatic test_collision();
    set_idle(); we[0] = 1'b1; addr[0] = 10'd9; wd[0] = 32'h11223344; be[0] = 4'hF;
    cycle();
    set_idle();
    we[0] = 1'b1; addr[0] = 10'd9; wd[0] = 32'hAABBCCDD; be[0] = 4'b0011;
    we[1] = 1'b1; addr[1] = 10'd9; wd[1] = 32'h55667788; be[1] = 4'b0110; re[1] = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_c[d] !== 1'b1) begin bad++; $display("FAIL coll_pulse d%0d: got %b want 1", d, out_c[d]); end
    end
    total++;
    if (out_v[0][1] !== 1'b1 || out_d[0][1] !== 32'h1166CCDD) begin bad++; $display("FAIL coll_rd_l1: got v=%b d=%h want v=1 d=1166ccdd", out_v[0][1], out_d[0][1]); end
    // Both ports strobe writes with no lanes enabled: nothing changes, no pulse.
    set_idle();
    we[0] = 1'b1; addr[0] = 10'd9; wd[0] = 32'hFFFFFFFF; be[0] = 4'h0; re[0] = 1'b1;
    we[1] = 1'b1; addr[1] = 10'd9; wd[1] = 32'hFFFFFFFF; be[1] = 4'h0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_c[d] !== 1'b0) begin bad++; $display("FAIL coll_once d%0d: got %b want 0", d, out_c[d]); end
    end
    total++;
    if (out_v[1][1] !== 1'b1 || out_d[1][1] !== 32'h1166CCDD) begin bad++; $display("FAIL coll_rd_l2: got v=%b d=%h want v=1 d=1166ccdd", out_v[1][1], out_d[1][1]); end
    total++;
    if (out_d[0][0] !== 32'h1166CCDD) begin bad++; $display("FAIL coll_mem: got %h want 1166ccdd", out_d[0][0]); end
  endtask

  task automatic test_forward();
    set_idle();
    we[0] = 1'b1; addr[0] = 10'd7; wd[0] = 32'h0000CAFE; be[0] = 4'hF;
    re[1] = 1'b1; addr[1] = 10'd7;
    cycle();
    total++;
    if (out_v[0][1] !== 1'b1 || out_d[0][1] !== 32'h0000CAFE) begin bad++; $display("FAIL fwd_l1: got v=%b d=%h want v=1 d=0000cafe", out_v[0][1], out_d[0][1]); end
    set_idle();
    cycle();
    total++;
    if (out_v[1][1] !== 1'b1 || out_d[1][1] !== 32'h0000CAFE) begin bad++; $display("FAIL fwd_l2: got v=%b d=%h want v=1 d=0000cafe", out_v[1][1], out_d[1][1]); end
  endtask

  task automatic test_ce_hold();
    logic [W-1:0] held;
    set_idle(); re[0] = 1'b1; addr[0] = 10'd5;
    cycle();
    held = exp_d[1][0];
    total++;
    if (out_v[1][0] !== 1'b0) begin bad++; $display("FAIL ce_issue_l2: got v=%b want 0", out_v[1][0]); end
    for (int k = 0; k < 3; k++) begin
      set_idle(); ce[0] = 1'b0; re[0] = 1'b1; re[1] = 1'b1; addr[1] = 10'd9;
      cycle();
      total++;
      if (out_v[1][0] !== 1'b0 || out_d[1][0] !== held) begin bad++; $display("FAIL ce_freeze_l2 k%0d: got v=%b d=%h want v=0 d=%h", k, out_v[1][0], out_d[1][0], held); end
      total++;
      if (out_v[0][0] !== 1'b1 || out_d[0][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL ce_freeze_l1 k%0d: got v=%b d=%h want v=1 d=deadbeef", k, out_v[0][0], out_d[0][0]); end
      total++;
      if (out_v[0][1] !== 1'b1 || out_d[0][1] !== 32'h1166CCDD) begin bad++; $display("FAIL ce_port_b k%0d: got v=%b d=%h want v=1 d=1166ccdd", k, out_v[0][1], out_d[0][1]); end
    end
    set_idle();
    cycle();
    total++;
    if (out_v[1][0] !== 1'b1 || out_d[1][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL ce_resume_l2: got v=%b d=%h want v=1 d=deadbeef", out_v[1][0], out_d[1][0]); end
    total++;
    if (out_v[1][1] !== 1'b1 || out_d[1][1] !== 32'h1166CCDD) begin bad++; $display("FAIL ce_resume_b: got v=%b d=%h want v=1 d=1166ccdd", out_v[1][1], out_d[1][1]); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 2; k++) begin
      set_idle(); re[0] = 1'b1; addr[0] = 10'd5; re[1] = 1'b1; addr[1] = 10'd7;
      cycle();
    end
    total++;
    if (out_v[1][0] !== 1'b1) begin bad++; $display("FAIL rst_pre: got v=%b want 1", out_v[1][0]); end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        total++;
        if (out_v[d][p] !== 1'b0 || out_d[d][p] !== '0) begin bad++; $display("FAIL rst_mid d%0d p%0d: got v=%b d=%h want v=0 d=0", d, p, out_v[d][p], out_d[d][p]); end
      end
    end
    #1 rst = 1'b0;
    model_reset();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          total++;
          if (out_v[d][p] !== 1'b0) begin bad++; $display("FAIL rst_stale k%0d d%0d p%0d: got v=%b want 0", k, d, p, out_v[d][p]); end
        end
      end
    end
    re[0] = 1'b1; addr[0] = 10'd5;
    cycle();
    total++;
    if (out_v[0][0] !== 1'b1 || out_d[0][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_after_l1: got v=%b d=%h want v=1 d=deadbeef", out_v[0][0], out_d[0][0]); end
    set_idle();
    cycle();
    total++;
    if (out_v[1][0] !== 1'b1 || out_d[1][0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_after_l2: got v=%b d=%h want v=1 d=deadbeef", out_v[1][0], out_d[1][0]); end
  endtask

  task automatic test_out_of_range();
    set_idle();
    we[0] = 1'b1; re[0] = 1'b1; addr[0] = 10'd1000; wd[0] = 32'h12345678; be[0] = 4'hF;
    we[1] = 1'b1; addr[1] = 10'd1000; wd[1] = 32'h9ABCDEF0; be[1] = 4'hF;
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_c[d] !== 1'b0) begin bad++; $display("FAIL oor_coll d%0d: got %b want 0", d, out_c[d]); end
    end
    total++;
    if (out_v[0][0] !== 1'b1 || out_d[0][0] !== '0) begin bad++; $display("FAIL oor_l1: got v=%b d=%h want v=1 d=0", out_v[0][0], out_d[0][0]); end
    set_idle();
    cycle();
    total++;
    if (out_v[1][0] !== 1'b1 || out_d[1][0] !== '0) begin bad++; $display("FAIL oor_l2: got v=%b d=%h want v=1 d=0", out_v[1][0], out_d[1][0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        int r;
        r = $urandom_range(0, 15);
        ce[p]   = ($urandom_range(0, 9) != 0);
        addr[p] = (r < 8) ? AW'(r) : AW'(990 + r);
        wd[p]   = $urandom;
        be[p]   = NB'($urandom);
        we[p]   = 1'($urandom_range(0, 1));
        re[p]   = 1'($urandom_range(0, 1));
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          total++;
          if (out_v[d][p] !== exp_v[d][p]) begin bad++; $display("FAIL rnd_valid n%0d d%0d p%0d: got %b want %b", n, d, p, out_v[d][p], exp_v[d][p]); end
          total++;
          if (out_d[d][p] !== exp_d[d][p]) begin bad++; $display("FAIL rnd_data n%0d d%0d p%0d: got %h want %h", n, d, p, out_d[d][p], exp_d[d][p]); end
        end
        total++;
        if (out_c[d] !== exp_c) begin bad++; $display("FAIL rnd_coll n%0d d%0d: got %b want %b", n, d, out_c[d], exp_c); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    for (int p = 0; p < 2; p++) begin
      cnt[p] = 0;
      rbase[p] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fill();
    test_write_read();
    test_collision();
    test_forward();
    test_ce_hold();
    test_reset_midflight();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
